// File: rtl/stats_frame_tx.sv
// stats_frame_tx: packs one set of statistics results into a fixed 13-byte frame.
// The frame is sent byte-by-byte over a valid/ready stream.
//
// Frame layout: HEADER, seq, sd[15:8], sd[7:0], mean (4 bytes, MSB first),
//               variance (4 bytes, MSB first), checksum (XOR of bytes 0..11).
//
// Ports:
//   clk          single clock, rising edge
//   rstn         synchronous active-low reset
//   start        level request from producer (four-phase with data_sent)
//   sd_in        16-bit standard deviation
//   mean_in      32-bit mean
//   variance_in  32-bit variance
//   tx_ready     downstream accepts tx_data this cycle
//   tx_data      frame byte
//   tx_valid     tx_data is valid
//   tx_sof       asserted with byte 0
//   tx_eof       asserted with byte 12 (checksum)
//   data_sent    frame fully accepted; held until start drops
//   busy         high whenever not idle
module stats_frame_tx #(
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter int unsigned FRAME_LEN = 13
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [15:0] sd_in,
    input  logic [31:0] mean_in,
    input  logic [31:0] variance_in,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        data_sent,
    output logic        busy
);

    localparam logic [3:0] LastIdx = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  frame_seq_q, frame_seq_d;
    logic [15:0] sd_q, sd_d;
    logic [31:0] mean_q, mean_d;
    logic [31:0] var_q, var_d;
    logic [7:0]  checksum;
    logic [7:0]  byte_sel;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            idx_q       <= 4'd0;
            seq_q       <= 8'd0;
            frame_seq_q <= 8'd0;
            sd_q        <= 16'd0;
            mean_q      <= 32'd0;
            var_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            frame_seq_q <= frame_seq_d;
            sd_q        <= sd_d;
            mean_q      <= mean_d;
            var_q       <= var_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        frame_seq_d = frame_seq_q;
        sd_d        = sd_q;
        mean_d      = mean_q;
        var_d       = var_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    sd_d        = sd_in;
                    mean_d      = mean_in;
                    var_d       = variance_in;
                    frame_seq_d = seq_q;
                    idx_d       = 4'd0;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = 4'd0;
                        seq_d   = seq_q + 8'd1;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StDone: begin
                // Wait for the producer to drop start before rearming.
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign checksum = HEADER ^ frame_seq_q ^ sd_q[15:8] ^ sd_q[7:0]
                    ^ mean_q[31:24] ^ mean_q[23:16] ^ mean_q[15:8] ^ mean_q[7:0]
                    ^ var_q[31:24] ^ var_q[23:16] ^ var_q[15:8] ^ var_q[7:0];

    always_comb begin
        byte_sel = 8'd0;
        case (idx_q)
            4'd0:    byte_sel = HEADER;
            4'd1:    byte_sel = frame_seq_q;
            4'd2:    byte_sel = sd_q[15:8];
            4'd3:    byte_sel = sd_q[7:0];
            4'd4:    byte_sel = mean_q[31:24];
            4'd5:    byte_sel = mean_q[23:16];
            4'd6:    byte_sel = mean_q[15:8];
            4'd7:    byte_sel = mean_q[7:0];
            4'd8:    byte_sel = var_q[31:24];
            4'd9:    byte_sel = var_q[23:16];
            4'd10:   byte_sel = var_q[15:8];
            4'd11:   byte_sel = var_q[7:0];
            4'd12:   byte_sel = checksum;
            default: byte_sel = 8'd0;
        endcase
    end

    // Outputs decode directly from registered state, so they hold stable under stall
    // and are all zero straight after reset.
    assign tx_valid  = (state_q == StSend);
    assign tx_data   = tx_valid ? byte_sel : 8'd0;
    assign tx_sof    = tx_valid && (idx_q == 4'd0);
    assign tx_eof    = tx_valid && (idx_q == LastIdx);
    assign data_sent = (state_q == StDone);
    assign busy      = (state_q != StIdle);

endmodule
